// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single main-memory port among NUM_CORES private caches.
// Round-robin arbitration with one transaction in flight at a time. Every
// granted access is broadcast on the snoop bus for one cycle and then issued
// to main memory. This block is the only snoop-bus driver in the system.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/we/addr/wdata  per-core request (core i addr at [i*ADDR_W +: ADDR_W],
//                            wdata at [i*8 +: 8])
//   req_ready                per-core one-cycle accept pulse
//   resp_valid               per-core one-cycle completion pulse
//   resp_data, resp_err      shared response byte / timeout flag, qualified by resp_valid
//   snoop_valid/core/cmd/addr  snoop broadcast (cmd 0 read, 1 RFO)
//   mem_valid/we/addr/wdata  request to main memory, held until done or timeout
//   mem_rdata, mem_done      memory read byte and one-cycle completion pulse
//
// All outputs are registered: the next output values are computed together
// with the next state, so each output reflects the state it is registered into.

module mem_bus_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 11,
   parameter int TIMEOUT   = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req_valid,
   input  logic [NUM_CORES-1:0]        req_we,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   input  logic [NUM_CORES*8-1:0]      req_wdata,
   output logic [NUM_CORES-1:0]        req_ready,
   output logic [NUM_CORES-1:0]        resp_valid,
   output logic [7:0]                  resp_data,
   output logic                        resp_err,
   output logic                        snoop_valid,
   output logic [1:0]                  snoop_core,
   output logic                        snoop_cmd,
   output logic [ADDR_W-1:0]           snoop_addr,
   output logic                        mem_valid,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [7:0]                  mem_wdata,
   input  logic [7:0]                  mem_rdata,
   input  logic                        mem_done
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SNOOP = 2'd1,
      MEM   = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic [7:0]          rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          rr_ptr_q, rr_ptr_d;

   logic [NUM_CORES-1:0] req_ready_d, resp_valid_d;
   logic [7:0]           resp_data_d;
   logic                 resp_err_d;
   logic                 snoop_valid_d, snoop_cmd_d;
   logic [1:0]           snoop_core_d;
   logic [ADDR_W-1:0]    snoop_addr_d;
   logic                 mem_valid_d, mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_d;
   logic [7:0]           mem_wdata_d;

   logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
   logic [7:0]           wdata_arr [NUM_CORES];

   logic                 win_found;
   logic [1:0]           win_idx;
   logic [2:0]           search_sum;

   // Unpack the flat per-core buses so the winner can be selected by index.
   always_comb begin
      for (int c = 0; c < NUM_CORES; c++) begin
         addr_arr[c]  = req_addr[c*ADDR_W +: ADDR_W];
         wdata_arr[c] = req_wdata[c*8 +: 8];
      end
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   // rr_ptr and the offset are both below NUM_CORES, so one conditional
   // subtraction is enough to wrap the sum.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = rr_ptr_q;
      search_sum = 3'd0;
      for (int i = 0; i < NUM_CORES; i++) begin
         search_sum = {1'b0, rr_ptr_q} + 3'(i);
         if (search_sum >= 3'(NUM_CORES)) begin
            search_sum = search_sum - 3'(NUM_CORES);
         end
         if (!win_found && req_valid[search_sum[1:0]]) begin
            win_found = 1'b1;
            win_idx   = search_sum[1:0];
         end
      end
   end

   // Next-state logic and the next value of every registered output.
   // Outputs default to zero so each one is only high in its own state.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;

      req_ready_d   = '0;
      resp_valid_d  = '0;
      resp_data_d   = 8'd0;
      resp_err_d    = 1'b0;
      snoop_valid_d = 1'b0;
      snoop_core_d  = 2'd0;
      snoop_cmd_d   = 1'b0;
      snoop_addr_d  = '0;
      mem_valid_d   = 1'b0;
      mem_we_d      = 1'b0;
      mem_addr_d    = '0;
      mem_wdata_d   = 8'd0;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d              = win_idx;
               we_d                 = req_we[win_idx];
               addr_d               = addr_arr[win_idx];
               wdata_d              = wdata_arr[win_idx];
               rdata_d              = 8'd0;
               cnt_d                = '0;
               state_d              = SNOOP;
               req_ready_d[win_idx] = 1'b1;
               snoop_valid_d        = 1'b1;
               snoop_core_d         = win_idx;
               snoop_cmd_d          = req_we[win_idx];
               snoop_addr_d         = addr_arr[win_idx];
            end
         end

         SNOOP: begin
            state_d     = MEM;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_we_d    = we_q;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata_q;
         end

         MEM: begin
            // A completion in the same cycle as the timeout takes priority.
            if (mem_done) begin
               rdata_d               = we_q ? 8'd0 : mem_rdata;
               state_d               = RESP;
               resp_valid_d[grant_q] = 1'b1;
               resp_data_d           = we_q ? 8'd0 : mem_rdata;
               resp_err_d            = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d                 = 1'b1;
               state_d               = RESP;
               resp_valid_d[grant_q] = 1'b1;
               resp_data_d           = rdata_q;
               resp_err_d            = 1'b1;
            end else begin
               cnt_d       = cnt_q + 1'b1;
               mem_valid_d = 1'b1;
               mem_we_d    = we_q;
               mem_addr_d  = addr_q;
               mem_wdata_d = wdata_q;
            end
         end

         RESP: begin
            rr_ptr_d = (grant_q == 2'(NUM_CORES - 1)) ? 2'd0 : grant_q + 2'd1;
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, transaction context and output registers. Reset abandons any
   // transaction in flight without issuing a response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= 2'd0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 8'd0;
         rdata_q     <= 8'd0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         rr_ptr_q    <= 2'd0;
         req_ready   <= '0;
         resp_valid  <= '0;
         resp_data   <= 8'd0;
         resp_err    <= 1'b0;
         snoop_valid <= 1'b0;
         snoop_core  <= 2'd0;
         snoop_cmd   <= 1'b0;
         snoop_addr  <= '0;
         mem_valid   <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 8'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         req_ready   <= req_ready_d;
         resp_valid  <= resp_valid_d;
         resp_data   <= resp_data_d;
         resp_err    <= resp_err_d;
         snoop_valid <= snoop_valid_d;
         snoop_core  <= snoop_core_d;
         snoop_cmd   <= snoop_cmd_d;
         snoop_addr  <= snoop_addr_d;
         mem_valid   <= mem_valid_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter: drives per-core requests and plays the
// part of main memory, checking grants, snoop broadcasts, memory requests and
// responses against hand-computed values.

module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_we;
   logic [43:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_ready;
   logic [3:0]  resp_valid;
   logic [7:0]  resp_data;
   logic        resp_err;
   logic        snoop_valid;
   logic [1:0]  snoop_core;
   logic        snoop_cmd;
   logic [10:0] snoop_addr;
   logic        mem_valid;
   logic        mem_we;
   logic [10:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_done;

   int compare_count;
   int mismatch_count;

   mem_bus_arbiter #(
      .NUM_CORES (4),
      .ADDR_W    (11),
      .TIMEOUT   (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_err    (resp_err),
      .snoop_valid (snoop_valid),
      .snoop_core  (snoop_core),
      .snoop_cmd   (snoop_cmd),
      .snoop_addr  (snoop_addr),
      .mem_valid   (mem_valid),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_done    (mem_done)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backstop so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // One cycle: inputs change and outputs are sampled 1 unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int core, input logic we,
                                input logic [10:0] addr, input logic [7:0] wdata);
      req_valid[core]          = 1'b1;
      req_we[core]             = we;
      req_addr[core*11 +: 11]  = addr;
      req_wdata[core*8 +: 8]   = wdata;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " req_ready"},   32'(req_ready),   32'd0);
      checkOutput({tag, " resp_valid"},  32'(resp_valid),  32'd0);
      checkOutput({tag, " resp_data"},   32'(resp_data),   32'd0);
      checkOutput({tag, " resp_err"},    32'(resp_err),    32'd0);
      checkOutput({tag, " snoop_valid"}, 32'(snoop_valid), 32'd0);
      checkOutput({tag, " snoop_core"},  32'(snoop_core),  32'd0);
      checkOutput({tag, " snoop_cmd"},   32'(snoop_cmd),   32'd0);
      checkOutput({tag, " snoop_addr"},  32'(snoop_addr),  32'd0);
      checkOutput({tag, " mem_valid"},   32'(mem_valid),   32'd0);
      checkOutput({tag, " mem_we"},      32'(mem_we),      32'd0);
      checkOutput({tag, " mem_addr"},    32'(mem_addr),    32'd0);
      checkOutput({tag, " mem_wdata"},   32'(mem_wdata),   32'd0);
   endtask

   // Serve one transaction starting from an IDLE cycle with requests already
   // driven. Memory completes on MEM cycle done_cycle (1 = first MEM cycle).
   // Ends in the IDLE cycle after RESP.
   task automatic serveOne(input string tag, input int core, input logic release_req,
                           input int done_cycle, input logic [7:0] rd,
                           input logic [7:0] exp_data, input logic exp_we,
                           input logic [10:0] exp_addr, input logic [7:0] exp_wdata);
      step();
      checkOutput({tag, " snoop_valid"}, 32'(snoop_valid), 32'd1);
      checkOutput({tag, " snoop_core"},  32'(snoop_core),  32'(core));
      checkOutput({tag, " snoop_cmd"},   32'(snoop_cmd),   32'(exp_we));
      checkOutput({tag, " snoop_addr"},  32'(snoop_addr),  32'(exp_addr));
      checkOutput({tag, " req_ready"},   32'(req_ready),   32'd1 << core);
      checkOutput({tag, " mem_valid in snoop"}, 32'(mem_valid), 32'd0);
      if (release_req) begin
         req_valid[core] = 1'b0;
      end
      step();
      checkOutput({tag, " mem_valid"}, 32'(mem_valid), 32'd1);
      checkOutput({tag, " mem_we"},    32'(mem_we),    32'(exp_we));
      checkOutput({tag, " mem_addr"},  32'(mem_addr),  32'(exp_addr));
      checkOutput({tag, " snoop_valid in mem"}, 32'(snoop_valid), 32'd0);
      checkOutput({tag, " req_ready in mem"},   32'(req_ready),   32'd0);
      for (int i = 1; i < done_cycle; i++) begin
         step();
      end
      checkOutput({tag, " mem_valid held"}, 32'(mem_valid), 32'd1);
      checkOutput({tag, " mem_wdata held"}, 32'(mem_wdata), 32'(exp_wdata));
      mem_done  = 1'b1;
      mem_rdata = rd;
      step();
      mem_done  = 1'b0;
      mem_rdata = 8'h00;
      checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd1 << core);
      checkOutput({tag, " resp_data"},  32'(resp_data),  32'(exp_data));
      checkOutput({tag, " resp_err"},   32'(resp_err),   32'd0);
      checkOutput({tag, " mem_valid in resp"}, 32'(mem_valid), 32'd0);
      step();
      checkOutput({tag, " resp_valid after"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int mem_cycles;
      compare_count  = 0;
      mismatch_count = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      mem_rdata = 8'h00;
      mem_done  = 1'b0;

      // Reset state.
      step();
      step();
      rst = 1'b0;
      checkAllZero("reset");

      // mem_done outside MEM has no effect.
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      checkOutput("stray done resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("stray done mem_valid",  32'(mem_valid),  32'd0);

      // 1. Single read from core1, memory answers on the third MEM cycle.
      applyStimulus(1, 1'b0, 11'h2A5, 8'h00);
      serveOne("read", 1, 1'b1, 3, 8'h5C, 8'h5C, 1'b0, 11'h2A5, 8'h00);

      // 2. Write from core0; read data from memory must not leak into resp_data.
      applyStimulus(0, 1'b1, 11'h7FF, 8'hA3);
      serveOne("write", 0, 1'b1, 2, 8'hEE, 8'h00, 1'b1, 11'h7FF, 8'hA3);

      // 3. All cores request continuously from reset: grants 0,1,2,3,0,1.
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(c, 1'b0, 11'(11'h100 + c), 8'h00);
      end
      step();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         serveOne($sformatf("rr%0d", k), k % 4, 1'b0, 1, 8'(8'h10 + k), 8'(8'h10 + k),
                  1'b0, 11'(11'h100 + (k % 4)), 8'h00);
      end
      req_valid = '0;

      // 4. Core2 served last, then core2 and core3 together: core3 first, then core2.
      applyStimulus(2, 1'b0, 11'h222, 8'h00);
      serveOne("core2 alone", 2, 1'b1, 1, 8'h22, 8'h22, 1'b0, 11'h222, 8'h00);
      applyStimulus(2, 1'b0, 11'h222, 8'h00);
      applyStimulus(3, 1'b1, 11'h333, 8'h33);
      serveOne("tie core3", 3, 1'b1, 1, 8'h99, 8'h00, 1'b1, 11'h333, 8'h33);
      serveOne("tie core2", 2, 1'b1, 1, 8'h44, 8'h44, 1'b0, 11'h222, 8'h00);

      // 5. Timeout: memory never answers core3.
      applyStimulus(3, 1'b0, 11'h0F0, 8'h00);
      step();
      checkOutput("timeout snoop_core", 32'(snoop_core), 32'd3);
      req_valid[3] = 1'b0;
      step();
      mem_cycles = 0;
      while (mem_valid && mem_cycles < 100) begin
         mem_cycles++;
         step();
      end
      checkOutput("timeout mem cycles", 32'(mem_cycles), 32'd64);
      checkOutput("timeout resp_valid", 32'(resp_valid), 32'b1000);
      checkOutput("timeout resp_err",   32'(resp_err),   32'd1);
      step();
      checkOutput("timeout err cleared", 32'(resp_err), 32'd0);
      applyStimulus(1, 1'b0, 11'h011, 8'h00);
      serveOne("after timeout", 1, 1'b1, 1, 8'h6B, 8'h6B, 1'b0, 11'h011, 8'h00);

      // Completion on the last allowed MEM cycle beats the timeout.
      applyStimulus(1, 1'b0, 11'h012, 8'h00);
      serveOne("done at limit", 1, 1'b1, 64, 8'h77, 8'h77, 1'b0, 11'h012, 8'h00);

      // 6. Reset during MEM abandons the transaction and clears rr_ptr (now 2).
      applyStimulus(2, 1'b0, 11'h0AA, 8'h00);
      step();
      req_valid[2] = 1'b0;
      step();
      checkOutput("pre-reset mem_valid", 32'(mem_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkAllZero("mid reset");
      step();
      step();
      checkOutput("post reset resp_valid", 32'(resp_valid), 32'd0);
      // With rr_ptr back at 0 core0 beats core3.
      applyStimulus(0, 1'b0, 11'h055, 8'h00);
      applyStimulus(3, 1'b0, 11'h066, 8'h00);
      serveOne("post reset", 0, 1'b1, 1, 8'h3C, 8'h3C, 1'b0, 11'h055, 8'h00);
      req_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
